sobel_frame_loader: RTL and testbench

SOBEL_FRAME_LOADER -- requirements
Module: sobel_frame_loader

---
 rtl/sobel_frame_loader.sv | 141 ++++++++++++++
 tb/tb_sobel_frame_loader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_loader.sv
// Streams a raster frame into the Sobel filter input RAM, then starts the filter and waits for it.
// Optional s_pixel_last framing check is enabled by defining SOBEL_LOADER_LAST_CHECK_EN.
module sobel_frame_loader #(
    parameter int WIDTH  = 512,
    parameter int HEIGHT = 512,
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        s_pixel_data,
    input  logic              s_pixel_valid,
    input  logic              s_pixel_last,
    output logic              s_pixel_ready,
    output logic [ADDR_W-1:0] in_address_a,
    output logic              in_write_en_a,
    output logic [7:0]        in_write_data_a,
    output logic              start,
    input  logic              ready,
    input  logic              finish,
    output logic              frame_done,
    output logic              frame_error
);

    typedef enum logic [1:0] {
        LOAD,
        START,
        RUN,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WIDTH * HEIGHT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              ready_q, ready_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              start_q, start_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

`ifndef SOBEL_LOADER_LAST_CHECK_EN
    logic unused_last;
    assign unused_last = s_pixel_last;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wr_en_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        error_d = 1'b0;
        case (state_q)
            LOAD: begin
                // ready_q is only ever high while in LOAD, so it alone qualifies a beat
                if (s_pixel_valid && ready_q) begin
                    wr_en_d = 1'b1;
                    addr_d  = count_q;
                    data_d  = s_pixel_data;
`ifdef SOBEL_LOADER_LAST_CHECK_EN
                    if (s_pixel_last && (count_q != LAST_IDX)) begin
                        error_d = 1'b1;
                        count_d = '0;
                    end else if (count_q == LAST_IDX) begin
                        error_d = ~s_pixel_last;
                        count_d = '0;
                        state_d = START;
                    end else begin
                        count_d = count_q + ADDR_W'(1);
                    end
`else
                    if (count_q == LAST_IDX) begin
                        count_d = '0;
                        state_d = START;
                    end else begin
                        count_d = count_q + ADDR_W'(1);
                    end
`endif
                end
            end
            START: begin
                if (ready) begin
                    start_d = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (finish) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                count_d = '0;
                state_d = LOAD;
            end
            default: begin
                state_d = LOAD;
                count_d = '0;
            end
        endcase
        ready_d = (state_d == LOAD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD;
            count_q <= '0;
            ready_q <= 1'b0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ready_q <= ready_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            start_q <= start_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign s_pixel_ready   = ready_q;
    assign in_write_en_a   = wr_en_q;
    assign in_address_a    = addr_q;
    assign in_write_data_a = data_q;
    assign start           = start_q;
    assign frame_done      = done_q;
    assign frame_error     = error_q;

endmodule

// File: tb/tb_sobel_frame_loader.sv
// Scoreboard bench for sobel_frame_loader on a 4x4 frame; the expected RAM write stream
// comes from a pixel-counting model and is checked by an independent monitor.
module tb_sobel_frame_loader;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int AW   = 8;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    s_pixel_data;
    logic          s_pixel_valid;
    logic          s_pixel_last;
    logic          s_pixel_ready;
    logic [AW-1:0] in_address_a;
    logic          in_write_en_a;
    logic [7:0]    in_write_data_a;
    logic          start;
    logic          flt_ready;
    logic          flt_finish;
    logic          frame_done;
    logic          frame_error;

    sobel_frame_loader #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
        .clk             (clk),
        .reset           (reset),
        .s_pixel_data    (s_pixel_data),
        .s_pixel_valid   (s_pixel_valid),
        .s_pixel_last    (s_pixel_last),
        .s_pixel_ready   (s_pixel_ready),
        .in_address_a    (in_address_a),
        .in_write_en_a   (in_write_en_a),
        .in_write_data_a (in_write_data_a),
        .start           (start),
        .ready           (flt_ready),
        .finish          (flt_finish),
        .frame_done      (frame_done),
        .frame_error     (frame_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  tb_count = 0;
    int  exp_frames = 0;
    int  exp_errors = 0;
    int  exp_done = 0;
    int  start_cnt = 0;
    int  done_cnt = 0;
    int  err_cnt = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference model: every accepted beat lands at the current pixel index, which
    // advances per beat and restarts at each frame boundary or framing error.
    task automatic modelAccept(input logic [7:0] d, input bit last);
        wr_t w;
        w.addr = AW'(tb_count);
        w.data = d;
        exp_q.push_back(w);
`ifdef SOBEL_LOADER_LAST_CHECK_EN
        if (last && tb_count != NPIX - 1) begin
            exp_errors++;
            tb_count = 0;
        end else if (tb_count == NPIX - 1) begin
            if (!last) exp_errors++;
            tb_count = 0;
            exp_frames++;
        end else begin
            tb_count++;
        end
`else
        if (last) begin end
        if (tb_count == NPIX - 1) begin
            tb_count = 0;
            exp_frames++;
        end else begin
            tb_count++;
        end
`endif
    endtask

    // Monitor: pops the scoreboard on every RAM write and tallies control pulses.
    always @(negedge clk) begin
        if (in_write_en_a === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_write: got addr %0d data %0d, expected no write",
                         in_address_a, in_write_data_a);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                checkOutput("write_addr", 32'(in_address_a), 32'(w.addr));
                checkOutput("write_data", 32'(in_write_data_a), 32'(w.data));
            end
        end
        if (start === 1'b1) begin
            start_cnt++;
            checkOutput("writes_before_start", exp_q.size(), 0);
        end
        if (frame_done === 1'b1) done_cnt++;
        if (frame_error === 1'b1) err_cnt++;
    end

    // mode 0: valid every cycle, 1: valid alternating, 2: random valid
    task automatic applyStimulus(input int n_beats, input int last_a, input int last_b,
                                 input int mode, input bit seq_data);
        int sent = 0;
        int budget = 0;
        bit v;
        logic [7:0] d;
        while (sent < n_beats && budget < 1000) begin
            @(negedge clk);
            budget++;
            case (mode)
                0:       v = 1'b1;
                1:       v = budget[0];
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            d = seq_data ? 8'(sent) : 8'($urandom);
            s_pixel_valid = v;
            s_pixel_data  = d;
            s_pixel_last  = v && (sent == last_a || sent == last_b);
            if (v && s_pixel_ready === 1'b1) begin
                modelAccept(d, s_pixel_last);
                sent++;
            end
        end
        @(negedge clk);
        s_pixel_valid = 1'b0;
        s_pixel_last  = 1'b0;
        checkOutput("beats_accepted", sent, n_beats);
    endtask

    task automatic waitStart();
        int n = 0;
        while (start !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("start_seen", 32'(start), 1);
        @(negedge clk);
        checkOutput("start_one_cycle", 32'(start), 0);
    endtask

    task automatic finishFrame(input int delay);
        repeat (delay - 1) @(negedge clk);
        flt_finish = 1'b1;
        @(negedge clk);
        flt_finish = 1'b0;
        @(negedge clk);
        exp_done++;
        checkOutput("frame_done_pulse", 32'(frame_done), 1);
        checkOutput("ready_after_done", 32'(s_pixel_ready), 1);
        @(negedge clk);
        checkOutput("frame_done_one_cycle", 32'(frame_done), 0);
    endtask

    task automatic checkCounts(input string tag);
        #1;
        checkOutput({tag, "_starts"}, start_cnt, exp_frames);
        checkOutput({tag, "_dones"}, done_cnt, exp_done);
        checkOutput({tag, "_errors"}, err_cnt, exp_errors);
        checkOutput({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic checkResetState();
        checkOutput("rst_ready", 32'(s_pixel_ready), 0);
        checkOutput("rst_wr_en", 32'(in_write_en_a), 0);
        checkOutput("rst_addr", 32'(in_address_a), 0);
        checkOutput("rst_data", 32'(in_write_data_a), 0);
        checkOutput("rst_start", 32'(start), 0);
        checkOutput("rst_done", 32'(frame_done), 0);
        checkOutput("rst_error", 32'(frame_error), 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int high_cnt;
        reset         = 1'b1;
        s_pixel_data  = '0;
        s_pixel_valid = 1'b0;
        s_pixel_last  = 1'b0;
        flt_ready     = 1'b1;
        flt_finish    = 1'b0;
        repeat (3) @(negedge clk);
        checkResetState();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(s_pixel_ready), 1);

        // Sequential data, valid every cycle
        applyStimulus(NPIX, NPIX - 1, -1, 0, 1'b1);
        waitStart();
        finishFrame(20);
        checkCounts("basic");

        // Alternating valid
        applyStimulus(NPIX, NPIX - 1, -1, 1, 1'b0);
        waitStart();
        finishFrame(7);
        checkCounts("toggle");

        // Filter not ready for 10 cycles after the frame is loaded
        flt_ready = 1'b0;
        applyStimulus(NPIX, NPIX - 1, -1, 2, 1'b0);
        high_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (start !== 1'b0) high_cnt++;
            if (s_pixel_ready !== 1'b0) high_cnt++;
        end
        checkOutput("held_while_not_ready", high_cnt, 0);
        flt_ready = 1'b1;
        @(negedge clk);
        checkOutput("start_on_ready", 32'(start), 1);
        @(negedge clk);
        checkOutput("start_single", 32'(start), 0);
        finishFrame(5);
        checkCounts("ready_wait");

        // Premature s_pixel_last on beat 5
`ifdef SOBEL_LOADER_LAST_CHECK_EN
        applyStimulus(NPIX + 6, 5, NPIX + 5, 2, 1'b0);
`else
        applyStimulus(NPIX, 5, NPIX - 1, 2, 1'b0);
`endif
        waitStart();
        finishFrame(3);
        checkCounts("early_last");

        // Frame with no s_pixel_last at all
        applyStimulus(NPIX, -1, -1, 0, 1'b0);
        waitStart();
        finishFrame(2);
        checkCounts("no_last");

        // Reset after beat 8 abandons the frame
        applyStimulus(9, -1, -1, 0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkResetState();
        reset = 1'b0;
        tb_count = 0;
        @(negedge clk);
        checkOutput("ready_after_midframe_reset", 32'(s_pixel_ready), 1);
        checkCounts("midframe_reset");
        applyStimulus(NPIX, NPIX - 1, -1, 2, 1'b0);
        waitStart();
        finishFrame(4);
        checkCounts("after_reset");

        // Reset during RUN: no frame_done, late finish ignored
        applyStimulus(NPIX, NPIX - 1, -1, 0, 1'b0);
        waitStart();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkResetState();
        reset = 1'b0;
        @(negedge clk);
        flt_finish = 1'b1;
        repeat (2) @(negedge clk);
        flt_finish = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("ready_after_run_reset", 32'(s_pixel_ready), 1);
        checkCounts("run_reset");

        // finish in LOAD ignored; valid held during RUN ignored
        flt_finish = 1'b1;
        repeat (3) @(negedge clk);
        flt_finish = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_load_finish", 32'(s_pixel_ready), 1);
        checkCounts("load_finish");
        applyStimulus(NPIX, NPIX - 1, -1, 0, 1'b0);
        waitStart();
        high_cnt = 0;
        repeat (6) begin
            s_pixel_valid = 1'b1;
            s_pixel_data  = 8'($urandom);
            @(negedge clk);
            if (s_pixel_ready !== 1'b0) high_cnt++;
        end
        s_pixel_valid = 1'b0;
        checkOutput("ready_low_in_run", high_cnt, 0);
        finishFrame(2);
        checkCounts("valid_in_run");

        repeat (3) @(negedge clk);
        checkCounts("final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
